// File: rtl/msrv32_load_store_unit.sv
// Stage-3 load/store unit: one req/ack data-bus transaction per load or store,
// with lane steering, load extension, misalignment detection and a bus timeout.
module msrv32_load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        ms_risc32_mp_clk_in,
    input  logic        ms_risc32_mp_rst_n_in,
    input  logic        mem_rd_req_in,
    input  logic        mem_wr_req_in,
    input  logic        flush_in,
    input  logic [31:0] iadder_out_reg_in,
    input  logic [31:0] rs2_reg_in,
    input  logic [1:0]  load_size_reg_in,
    input  logic        load_unsigned_reg_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_wstrb_out,
    input  logic        dmem_ack_in,
    input  logic        dmem_err_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        hold_out,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        misaligned_exc_out,
    output logic        bus_err_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic [1:0]         off_q;
    logic [1:0]         size_q;
    logic               unsigned_q;

    logic               access;
    logic               aligned;
    logic               start;
    logic               misaligned;
    logic               timeout;
    logic [31:0]        wdata_c;
    logic [3:0]         wstrb_c;
    logic [31:0]        byte_lane;
    logic [31:0]        half_lane;
    logic [31:0]        load_ext;

    assign access     = mem_rd_req_in | mem_wr_req_in;
    assign start      = (state_q == IDLE) & access & ~flush_in & aligned;
    assign misaligned = (state_q == IDLE) & access & ~flush_in & ~aligned;
    assign hold_out   = (state_q == BUSY) | start;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign timeout    = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // Size-dependent alignment check and store lane replication.
    always_comb begin
        aligned = 1'b1;
        wdata_c = rs2_reg_in;
        wstrb_c = 4'b1111;
        case (load_size_reg_in)
            2'b00: begin
                aligned = 1'b1;
                wdata_c = {4{rs2_reg_in[7:0]}};
                wstrb_c = 4'b0001 << iadder_out_reg_in[1:0];
            end
            2'b01: begin
                aligned = ~iadder_out_reg_in[0];
                wdata_c = {2{rs2_reg_in[15:0]}};
                wstrb_c = 4'b0011 << {iadder_out_reg_in[1], 1'b0};
            end
            default: begin
                aligned = (iadder_out_reg_in[1:0] == 2'b00);
                wdata_c = rs2_reg_in;
                wstrb_c = 4'b1111;
            end
        endcase
    end

    assign byte_lane = dmem_rdata_in >> {off_q, 3'b000};
    assign half_lane = dmem_rdata_in >> {off_q[1], 4'b0000};

    always_comb begin
        load_ext = dmem_rdata_in;
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'b0, byte_lane[7:0]}
                                           : {{24{byte_lane[7]}}, byte_lane[7:0]};
            2'b01:   load_ext = unsigned_q ? {16'b0, half_lane[15:0]}
                                           : {{16{half_lane[15]}}, half_lane[15:0]};
            default: load_ext = dmem_rdata_in;
        endcase
    end

    always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_n_in) begin
        if (!ms_risc32_mp_rst_n_in) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            off_q              <= 2'b00;
            size_q             <= 2'b00;
            unsigned_q         <= 1'b0;
            dmem_req_out       <= 1'b0;
            dmem_we_out        <= 1'b0;
            dmem_addr_out      <= 32'b0;
            dmem_wdata_out     <= 32'b0;
            dmem_wstrb_out     <= 4'b0;
            load_data_out      <= 32'b0;
            load_valid_out     <= 1'b0;
            misaligned_exc_out <= 1'b0;
            bus_err_out        <= 1'b0;
        end else begin
            load_valid_out     <= 1'b0;
            bus_err_out        <= 1'b0;
            misaligned_exc_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    misaligned_exc_out <= misaligned;
                    if (start) begin
                        state_q        <= BUSY;
                        cnt_q          <= '0;
                        dmem_req_out   <= 1'b1;
                        // A simultaneous rd+wr request is resolved as a store.
                        dmem_we_out    <= mem_wr_req_in;
                        dmem_addr_out  <= {iadder_out_reg_in[31:2], 2'b00};
                        dmem_wdata_out <= wdata_c;
                        dmem_wstrb_out <= mem_wr_req_in ? wstrb_c : 4'b0000;
                        off_q          <= iadder_out_reg_in[1:0];
                        size_q         <= load_size_reg_in;
                        unsigned_q     <= load_unsigned_reg_in;
                    end
                end
                BUSY: begin
                    // An ack in the final counted cycle still wins over the timeout.
                    if (dmem_ack_in) begin
                        state_q      <= DONE;
                        cnt_q        <= '0;
                        dmem_req_out <= 1'b0;
                        if (dmem_err_in) begin
                            bus_err_out   <= 1'b1;
                            load_data_out <= 32'b0;
                        end else if (!dmem_we_out) begin
                            load_valid_out <= 1'b1;
                            load_data_out  <= load_ext;
                        end
                    end else if (timeout) begin
                        state_q       <= DONE;
                        cnt_q         <= '0;
                        dmem_req_out  <= 1'b0;
                        bus_err_out   <= 1'b1;
                        load_data_out <= 32'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_load_store_unit.sv
// Randomized self-checking bench for msrv32_load_store_unit against an
// arithmetic reference model of lane steering, extension and bus timing.
module tb_msrv32_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic        wr_req;
    logic        flush;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [1:0]  size;
    logic        uns;
    logic        req;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        hold;
    logic [31:0] load_data;
    logic        load_valid;
    logic        mis;
    logic        bus_err;

    int          n_vec;
    int          n_err;
    logic [31:0] last_ld;

    msrv32_load_store_unit #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ms_risc32_mp_clk_in  (clk),
        .ms_risc32_mp_rst_n_in(rst_n),
        .mem_rd_req_in        (rd_req),
        .mem_wr_req_in        (wr_req),
        .flush_in             (flush),
        .iadder_out_reg_in    (addr),
        .rs2_reg_in           (rs2),
        .load_size_reg_in     (size),
        .load_unsigned_reg_in (uns),
        .dmem_req_out         (req),
        .dmem_we_out          (we),
        .dmem_addr_out        (maddr),
        .dmem_wdata_out       (wdata),
        .dmem_wstrb_out       (wstrb),
        .dmem_ack_in          (ack),
        .dmem_err_in          (err),
        .dmem_rdata_in        (rdata),
        .hold_out             (hold),
        .load_data_out        (load_data),
        .load_valid_out       (load_valid),
        .misaligned_exc_out   (mis),
        .bus_err_out          (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, req, 0);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_addr"}, maddr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_wstrb"}, wstrb, 0);
        chk({tag, "_ldata"}, load_data, 0);
        chk({tag, "_lvalid"}, load_valid, 0);
        chk({tag, "_mis"}, mis, 0);
        chk({tag, "_berr"}, bus_err, 0);
    endtask

    // a_d: BUSY cycle index (0-based) in which ack arrives; <0 means never.
    task automatic access(input bit a_rd, input bit a_wr, input logic [31:0] a_addr,
                          input logic [31:0] a_rs2, input logic [1:0] a_size, input bit a_uns,
                          input int a_d, input bit a_e, input logic [31:0] a_rdata,
                          input bit a_fl);
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] ext;
        int          off;
        int          blen;
        int          n;
        bit          aligned;
        bit          to;
        bit          errx;
        bit          is_st;

        off   = int'(a_addr % 4);
        is_st = a_wr;
        if (a_size == 2'd0) begin
            aligned   = 1'b1;
            exp_wdata = {24'b0, a_rs2[7:0]} * 32'h0101_0101;
            exp_wstrb = 4'(1 << off);
            ext       = (a_rdata >> (8 * off)) & 32'hFF;
            if (!a_uns && ext >= 32'd128) ext = ext - 32'd256;
        end else if (a_size == 2'd1) begin
            aligned   = (off % 2) == 0;
            exp_wdata = {16'b0, a_rs2[15:0]} * 32'h0001_0001;
            exp_wstrb = 4'(3 << (off & 2));
            ext       = (a_rdata >> (8 * (off & 2))) & 32'hFFFF;
            if (!a_uns && ext >= 32'd32768) ext = ext - 32'd65536;
        end else begin
            aligned   = (off == 0);
            exp_wdata = a_rs2;
            exp_wstrb = 4'hF;
            ext       = a_rdata;
        end
        if (!is_st) exp_wstrb = 4'h0;

        @(posedge clk); #1;
        rd_req = a_rd; wr_req = a_wr; addr = a_addr; rs2 = a_rs2;
        size = a_size; uns = a_uns; flush = 1'b0; ack = 1'b0; err = 1'b0;
        #1;
        chk("hold_start", hold, aligned);
        if (!aligned) begin
            @(posedge clk); #1;
            rd_req = 1'b0; wr_req = 1'b0;
            chk("mis_pulse", mis, 1);
            chk("mis_noreq", req, 0);
            @(posedge clk); #1;
            chk("mis_clear", mis, 0);
            chk("mis_noreq2", req, 0);
            return;
        end

        @(posedge clk); #1;
        chk("req_rise", req, 1);
        chk("we", we, is_st);
        chk("addr", maddr, {a_addr[31:2], 2'b00});
        chk("wdata", wdata, exp_wdata);
        chk("wstrb", wstrb, exp_wstrb);

        to   = (a_d < 0) || (a_d >= int'(TO));
        blen = to ? int'(TO) : a_d + 1;
        n    = 0;
        while (req === 1'b1 && n < 20) begin
            chk("hold_busy", hold, 1);
            chk("addr_stable", maddr, {a_addr[31:2], 2'b00});
            chk("wstrb_stable", wstrb, exp_wstrb);
            if (a_fl) flush = 1'b1;
            if (n == a_d) begin
                ack = 1'b1; err = a_e; rdata = a_rdata;
            end
            @(posedge clk); #1;
            ack = 1'b0; err = 1'b0; rdata = $urandom;
            n++;
        end
        chk("busy_len", n, blen);

        errx = to || a_e;
        if (errx) last_ld = 32'b0;
        else if (!is_st) last_ld = ext;
        chk("done_hold", hold, 0);
        chk("done_req", req, 0);
        chk("done_valid", load_valid, !errx && !is_st);
        chk("done_berr", bus_err, errx);
        chk("load_data", load_data, last_ld);

        @(posedge clk); #1;
        rd_req = 1'b0; wr_req = 1'b0; flush = 1'b0;
        chk("pulse_end", {load_valid, bus_err, req}, 0);
        chk("ldata_hold", load_data, last_ld);
    endtask

    initial begin
        n_vec = 0; n_err = 0; last_ld = 32'b0;
        rst_n = 1'b0;
        rd_req = 0; wr_req = 0; flush = 0; addr = 0; rs2 = 0; size = 0; uns = 0;
        ack = 0; err = 0; rdata = 0;
        #22;
        chk_all_zero("reset");
        chk("reset_hold", hold, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        access(1, 0, 32'h0000_1003, 32'h0, 2'd0, 0, 0, 0, 32'h80FF_FF12, 0);
        chk("byte_load_val", last_ld, 32'hFFFF_FF80);
        access(0, 1, 32'h0000_2002, 32'h1234_ABCD, 2'd1, 0, 3, 0, 32'h0, 0);
        access(1, 0, 32'h0000_3001, 32'h0, 2'd2, 0, 0, 0, 32'h0, 0);
        access(1, 0, 32'h0000_4000, 32'h0, 2'd2, 0, -1, 0, 32'h0, 0);
        access(1, 0, 32'h0000_5000, 32'h0, 2'd2, 0, 1, 0, 32'hDEAD_BEEF, 1);
        access(1, 1, 32'h0000_6001, 32'hA5A5_5AC3, 2'd0, 1, 0, 0, 32'h0, 0);
        access(1, 0, 32'h0000_7002, 32'h0, 2'd1, 0, 2, 1, 32'h1111_2222, 0);

        // Flush in IDLE suppresses both the access and a misaligned pulse.
        @(posedge clk); #1;
        rd_req = 1'b1; flush = 1'b1; addr = 32'h0000_3001; size = 2'd2;
        #1;
        chk("flush_hold", hold, 0);
        @(posedge clk); #1;
        chk("flush_noreq", req, 0);
        chk("flush_nomis", mis, 0);
        rd_req = 1'b0; flush = 1'b0;

        // Reset during the second BUSY cycle.
        @(posedge clk); #1;
        rd_req = 1'b1; addr = 32'h0000_0044; size = 2'd2; uns = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_busy", req, 1);
        @(posedge clk); #3;
        rd_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        chk("midrst_hold", hold, 0);
        last_ld = 32'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 0, 32'h0000_0002, 32'h0, 2'd1, 1, 0, 0, 32'h8001_0000, 0);
        chk("post_rst_half", last_ld, 32'h0000_8001);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            access(sel != 1, (sel == 1) || (sel == 2), $urandom, $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 5)), $urandom_range(0, 5) == 0, $urandom,
                   1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
